// File: rtl/joypad_p1_register_if.sv
// CPU-side FF00 (P1/JOYP) bus between the register stage and the CPU/IF logic.
// master = CPU side, slave = joypad register stage.
interface joypad_p1_register_if;
   logic [7:0] FF00_data_in;
   logic       FF00_load_in;
   logic [7:0] FF00_data_out;
   logic       joypad_interrupt;

   modport master (
      output FF00_data_in,
      output FF00_load_in,
      input  FF00_data_out,
      input  joypad_interrupt
   );

   modport slave (
      input  FF00_data_in,
      input  FF00_load_in,
      output FF00_data_out,
      output joypad_interrupt
   );
endinterface

// File: rtl/joypad_p1_register.sv
// Game Boy P1/JOYP register stage: synchronizes and debounces the NES reader's
// active-low button vector, holds the select bits and raises the joypad IRQ.
module joypad_p1_register #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [7:0]              buttons_n,
   joypad_p1_register_if.slave     cpu,
   output logic [7:0]              buttons_stable
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0]       sync1_q, sync1_d;
   logic [7:0]       sync2_q, sync2_d;
   logic [7:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       stable_q, stable_d;
   logic [1:0]       sel_q, sel_d;
   logic [7:0]       data_out_q, data_out_d;
   logic             irq_q, irq_d;

   logic [3:0]       nibble_next;
   logic             unused_data_bits;

   // Only bits 5:4 of a CPU write carry meaning for this register.
   assign unused_data_bits = ^{cpu.FF00_data_in[7:6], cpu.FF00_data_in[3:0]};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      sync1_d  = buttons_n;
      sync2_d  = sync1_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;

      // One shared counter: any change of the sampled vector restarts qualification.
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = cand_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      sel_d = sel_q;
      if (cpu.FF00_load_in) begin
         sel_d = cpu.FF00_data_in[5:4];
      end
   end

   always_comb begin
      nibble_next = (sel_q[0] ? 4'hF : stable_q[3:0]) &
                    (sel_q[1] ? 4'hF : stable_q[7:4]);
      data_out_d  = {2'b11, sel_q, nibble_next};
      // A pulse fires only for lines currently shown high that are about to read low.
      irq_d       = |(data_out_q[3:0] & ~nibble_next);
   end

   always_ff @(posedge clock) begin
      // NOTE: reset is synchronous, sampled on the clock edge like any other input.
      if (!reset_n) begin
         sync1_q    <= 8'hFF;
         sync2_q    <= 8'hFF;
         cand_q     <= 8'hFF;
         cnt_q      <= '0;
         stable_q   <= 8'hFF;
         sel_q      <= 2'b11;
         data_out_q <= 8'hFF;
         irq_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         stable_q   <= stable_d;
         sel_q      <= sel_d;
         data_out_q <= data_out_d;
         irq_q      <= irq_d;
      end
   end

   assign cpu.FF00_data_out    = data_out_q;
   assign cpu.joypad_interrupt = irq_q;
   assign buttons_stable       = stable_q;

endmodule

// File: tb/tb_joypad_p1_register.sv
// Scoreboard bench for joypad_p1_register: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_joypad_p1_register;

   localparam int K_DO  = 0;
   localparam int K_IRQ = 1;
   localparam int K_STB = 2;

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] val;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] buttons_n;
   logic [7:0] buttons_stable;

   joypad_p1_register_if cpu ();

   joypad_p1_register #(
      .DEBOUNCE_CYCLES (16),
      .CNT_W           (8)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .buttons_n      (buttons_n),
      .cpu            (cpu.slave),
      .buttons_stable (buttons_stable)
   );

   always #5 clock = ~clock;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%02h expected=%02h", name, cyc, act, exp_v);
      end
   endtask

   function automatic string kind_name(input int kind);
      case (kind)
         K_DO:    return "FF00_data_out";
         K_IRQ:   return "joypad_interrupt";
         default: return "buttons_stable";
      endcase
   endfunction

   function automatic logic [7:0] sample(input int kind);
      case (kind)
         K_DO:    return cpu.FF00_data_out;
         K_IRQ:   return {7'd0, cpu.joypad_interrupt};
         default: return buttons_stable;
      endcase
   endfunction

   // Monitor: compares every expectation stamped for the current cycle.
   always @(negedge clock) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(kind_name(sb[i].kind), sample(sb[i].kind), sb[i].val);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL late_%s cycle=%0d stamped=%0d", kind_name(sb[i].kind), cyc, sb[i].cyc);
            sb.delete(i);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_at(input int dc, input int kind, input logic [7:0] v);
      exp_t e;
      e.cyc  = cyc + dc;
      e.kind = kind;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic expect_range(input int from, input int to, input int kind, input logic [7:0] v);
      for (int d = from; d <= to; d++) expect_at(d, kind, v);
   endtask

   task automatic write_sel(input logic [7:0] v);
      cpu.FF00_data_in = v;
      cpu.FF00_load_in = 1'b1;
      step(1);
      cpu.FF00_load_in = 1'b0;
   endtask

   initial begin
      reset_n          = 1'b0;
      buttons_n        = 8'h00;
      cpu.FF00_data_in = 8'h00;
      cpu.FF00_load_in = 1'b0;

      // Reset values held for 3 cycles, then 2 cycles after release.
      expect_range(1, 3, K_DO,  8'hFF);
      expect_range(1, 3, K_IRQ, 8'h00);
      expect_range(1, 3, K_STB, 8'hFF);
      step(3);
      reset_n   = 1'b1;
      buttons_n = 8'hFF;
      expect_range(1, 2, K_DO,  8'hFF);
      expect_range(1, 2, K_IRQ, 8'h00);
      expect_range(1, 2, K_STB, 8'hFF);
      step(4);

      // Direction group selected, r pressed: EF -> EE after 20 edges.
      write_sel(8'h20);
      buttons_n = 8'hFE;
      expect_at(1, K_DO, 8'hEF);
      expect_at(19, K_DO, 8'hEF);
      expect_at(20, K_DO, 8'hEE);
      expect_range(1, 19, K_IRQ, 8'h00);
      expect_at(20, K_IRQ, 8'h01);
      expect_at(21, K_IRQ, 8'h00);
      expect_at(18, K_STB, 8'hFF);
      expect_at(19, K_STB, 8'hFE);
      step(24);

      // Release r: rising line never interrupts.
      buttons_n = 8'hFF;
      expect_at(19, K_DO, 8'hEE);
      expect_at(20, K_DO, 8'hEF);
      expect_range(1, 22, K_IRQ, 8'h00);
      expect_at(19, K_STB, 8'hFF);
      step(24);

      // Glitch of 10 cycles must never reach buttons_stable.
      expect_range(1, 50, K_STB, 8'hFF);
      expect_range(1, 50, K_IRQ, 8'h00);
      expect_at(50, K_DO, 8'hEF);
      buttons_n = 8'h7F;
      step(10);
      buttons_n = 8'hFF;
      step(40);

      // Start pressed with both selects high: output stays FF.
      expect_at(1, K_DO, 8'hEF);
      expect_at(2, K_DO, 8'hFF);
      expect_range(1, 25, K_IRQ, 8'h00);
      expect_at(19, K_STB, 8'h7F);
      expect_at(25, K_DO, 8'hFF);
      buttons_n = 8'h7F;
      write_sel(8'h30);
      step(25);

      // Selecting the button group exposes start: D7 and one pulse.
      expect_at(1, K_DO, 8'hFF);
      expect_at(2, K_DO, 8'hD7);
      expect_at(1, K_IRQ, 8'h00);
      expect_at(2, K_IRQ, 8'h01);
      expect_range(3, 4, K_IRQ, 8'h00);
      write_sel(8'h10);
      step(4);

      // Deselecting: back to FF, no pulse.
      expect_at(2, K_DO, 8'hFF);
      expect_range(1, 4, K_IRQ, 8'h00);
      write_sel(8'h30);
      step(4);

      // Both groups selected, then a and l pressed: C7 then CC.
      expect_at(2, K_DO, 8'hC7);
      expect_at(2, K_IRQ, 8'h01);
      expect_at(3, K_IRQ, 8'h00);
      expect_at(19, K_DO, 8'hC7);
      expect_at(18, K_STB, 8'h7F);
      expect_at(19, K_STB, 8'hED);
      expect_at(20, K_DO, 8'hCC);
      expect_at(20, K_IRQ, 8'h01);
      expect_at(21, K_IRQ, 8'h00);
      buttons_n = 8'hED;
      write_sel(8'h00);
      step(24);

      // Reset in the middle of a debounce restarts the whole pipeline.
      expect_at(10, K_STB, 8'hED);
      expect_at(10, K_DO, 8'hCC);
      expect_range(11, 40, K_DO, 8'hFF);
      expect_range(11, 29, K_STB, 8'hFF);
      expect_at(30, K_STB, 8'h00);
      expect_range(11, 40, K_IRQ, 8'h00);
      buttons_n = 8'h00;
      step(10);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      step(30);

      for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/joypad_p1_register.md
# joypad_p1_register

CPU-facing P1/JOYP (FF00) joypad register stage, placed directly downstream of the NES serial controller reader. It takes the reader's eight active-low button levels from the other clock domain and synchronizes and debounces them. It holds the CPU-written select bits, returns the Game Boy P1 read value, and raises a one-cycle joypad interrupt request when any visible line falls 1→0.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable sync samples required before a vector change is accepted; legal range 2..255.
- CNT_W, default 8: width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  system clock; every register updates on its rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on clock.
- buttons_n  in  8  raw levels from the serial reader, active low, ordered {start, sel, b, a, dn, up, l, r}; asynchronous to clock.
- FF00_data_in  in  8  CPU write data; only bits 5:4 are used.
- FF00_load_in  in  1  CPU write strobe for FF00, one cycle per write.
- FF00_data_out  out  8  P1 read value {2'b11, sel_q[1:0], nibble[3:0]}.
- joypad_interrupt  out  1  one-cycle request pulse to the interrupt-flag logic (IF bit 4).
- buttons_stable  out  8  debounced vector in the buttons_n order, for debug.

## Operation
- **Synchronizer:** two flops per bit, sync1 then sync2, both reset to 8'hFF.
- **Debounce:** uses one shared counter for the whole vector, plus a candidate register.
  - If sync2 != candidate: candidate <= sync2 and count <= 0.
  - Else if count == DEBOUNCE_CYCLES-1: buttons_stable <= candidate. count holds at DEBOUNCE_CYCLES-1 and does not wrap.
  - Else: count <= count+1.
  - Reset values: candidate = 8'hFF, count = 0, buttons_stable = 8'hFF.
- **Select register:** sel_q resets to 2'b11. When FF00_load_in is high, sel_q <= FF00_data_in[5:4]. All other written bits are ignored.
- **Nibble selection:**
  - dir = stable[3:0] = {dn, up, l, r}.
  - btn = stable[7:4] = {start, sel, b, a}.
  - nibble_next = (sel_q[0] ? 4'hF : dir) & (sel_q[1] ? 4'hF : btn).
  - Both select bits low gives the AND of both groups. Both high gives 4'hF.
- **Read value:** FF00_data_out <= {2'b11, sel_q, nibble_next} every cycle. The output is registered. Bits 7:6 always read 1.
- **Interrupt:** joypad_interrupt <= |(FF00_data_out[3:0] & ~nibble_next).
  - It is high exactly in the cycle where FF00_data_out first shows the newly low bit.
  - Falls caused by a select write also request an interrupt. Rises never do.
  - Lines that stay low produce no further pulses.
- **Reset:** reset_n low at any edge, including mid-debounce or mid-pulse, forces every register to its reset value on that edge.
  - FF00_data_out = 8'hFF, joypad_interrupt = 0, buttons_stable = 8'hFF, sel_q = 2'b11.
  - No interrupt is produced in the first cycle after reset releases.
  - With both selects high, the output stays 8'hFF until the CPU writes a select.

## Timing
- **buttons_n to buttons_stable:** buttons_n changes and is held before edge 1.
  - sync2 shows the change after edge 2.
  - candidate updates at edge 3.
  - buttons_stable updates at edge DEBOUNCE_CYCLES+3.
  - FF00_data_out and the interrupt follow at edge DEBOUNCE_CYCLES+4, which is 20 edges for the default.
- **Glitch rejection:** a change that reverts within DEBOUNCE_CYCLES sync cycles restarts the counter and never reaches buttons_stable.
- **Select write:** a write at edge N updates sel_q at edge N. FF00_data_out reflects the new select at edge N+1.
- **Simultaneous events:** a select write in the same cycle as a buttons_stable update is combined at edge N+1, and one interrupt evaluation covers both.
- **Interrupt pulse:** exactly one cycle wide. No handshake and no ack; the IF logic latches the pulse.
- **Throughput:** one register update per cycle, no stalls.

## Test plan
- **Reset values:** hold reset_n=0 for 3 cycles with buttons_n=8'h00 → FF00_data_out=8'hFF, joypad_interrupt=0, buttons_stable=8'hFF; after release, both stay at reset values for the next 2 cycles.
- **Direction press:** write FF00=8'h20 (direction group), then set buttons_n=8'hFE (r pressed) → FF00_data_out goes 8'hEF→8'hEE exactly 20 edges later, with a single-cycle joypad_interrupt in that same cycle.
- **Glitch rejection:** pulse buttons_n to 8'h7F for 10 cycles, then back to 8'hFF (DEBOUNCE_CYCLES=16) → buttons_stable stays 8'hFF and no interrupt fires.
- **Select-driven interrupt:** start pressed and stable with select=8'h30 (out 8'hFF); write 8'h10 → out=8'hD7 one edge after the write, joypad_interrupt pulses once; writing 8'h30 again gives out 8'hFF and no pulse.
- **Both groups selected:** write 8'h00 with a and l pressed (buttons_n=8'hED) → FF00_data_out=8'hCC.
- **Reset mid-debounce:** buttons_n=8'h00, assert reset_n=0 at cycle 10 of the debounce for 1 cycle → after release, buttons_stable updates only DEBOUNCE_CYCLES+3 edges after the release edge; FF00_data_out is 8'hFF during and after reset.
